memctl_mc: RTL and testbench

- Parametrised multi-channel data-memory bridge; successor to the single-channel data request queue.
- Accepts read requests from NCH independent channels into per-channel FIFOs.
- Arbitrates round-robin onto one backing memory port with one request outstanding.
- Broadcasts each result on the memory bus tagged with its originating channel.

---
 rtl/memctl_mc_if.sv | 31 +++
 rtl/memctl_mc.sv | 144 ++++++++++++++
 tb/tb_memctl_mc.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memctl_mc_if.sv
// Request/result bus of the multi-channel data-memory bridge memctl_mc.
// The slave modport is the bridge's own view; the master modport is the client/memory side.
interface memctl_mc_if #(
  parameter int unsigned NCH = 2,
  parameter int unsigned CW  = 1,
  parameter int unsigned AW  = 16,
  parameter int unsigned DW  = 16
);
  logic [NCH-1:0]    re;
  logic [NCH*AW-1:0] raddr;
  logic [NCH-1:0]    full;
  logic [NCH-1:0]    ovf;
  logic              mem_re;
  logic [AW-1:0]     mem_raddr;
  logic              mem_ready;
  logic [DW-1:0]     mem_rdata;
  logic              dready;
  logic [AW-1:0]     draddr_out;
  logic [DW-1:0]     ddata;
  logic [CW-1:0]     dch;

  modport master (
    output re, raddr, mem_ready, mem_rdata,
    input  full, ovf, mem_re, mem_raddr, dready, draddr_out, ddata, dch
  );

  modport slave (
    input  re, raddr, mem_ready, mem_rdata,
    output full, ovf, mem_re, mem_raddr, dready, draddr_out, ddata, dch
  );
endinterface

// File: rtl/memctl_mc.sv
// Multi-channel read bridge: per-channel FIFOs, round-robin onto one memory port, one outstanding.
// Define MEMCTL_PRIO_EN to replace round-robin with fixed lowest-channel-first priority.
module memctl_mc #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned CW    = 1,
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  memctl_mc_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned NW = $clog2(DEPTH + 1);

  typedef enum logic {StIdle, StWait} state_e;

  state_e        state_q;
  logic          mem_re_q;
  logic [AW-1:0] mem_raddr_q;
  logic [CW-1:0] dch_q;

  logic [AW-1:0]  fifo_mem [NCH][DEPTH];
  logic [PW-1:0]  head_q   [NCH];
  logic [PW-1:0]  tail_q   [NCH];
  logic [NW-1:0]  count_q  [NCH];
  logic [NCH-1:0] ovf_q;

  logic [NCH-1:0] nonempty;
  logic [NCH-1:0] full;
  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;
  logic [CW-1:0]  winner;
  logic           issue;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      nonempty[i] = (count_q[i] != '0);
      full[i]     = (count_q[i] == NW'(DEPTH));
    end
  end

  // Full comes from the pre-edge count, so a push to a full FIFO drops even if it pops this edge.
  assign push  = bus.re & ~full;
  assign issue = (|nonempty) && ((state_q == StIdle) || bus.mem_ready);

`ifdef MEMCTL_PRIO_EN
  always_comb begin
    winner = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (nonempty[i]) winner = CW'(i);
    end
  end
`else
  logic [CW-1:0] last_q;
  logic [CW-1:0] rr_idx;
  logic          found;

  always_comb begin
    winner = '0;
    rr_idx = '0;
    found  = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      rr_idx = CW'((int'(last_q) + k) % NCH);
      if (!found && nonempty[rr_idx]) begin
        winner = rr_idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= CW'(NCH - 1);
    end else if (issue) begin
      last_q <= winner;
    end
  end
`endif

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      pop[i] = issue && (winner == CW'(i));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (push[i]) fifo_mem[i][tail_q[i]] <= bus.raddr[i*AW +: AW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (push[i]) tail_q[i] <= (tail_q[i] == PW'(DEPTH - 1)) ? '0 : tail_q[i] + 1'b1;
        if (pop[i])  head_q[i] <= (head_q[i] == PW'(DEPTH - 1)) ? '0 : head_q[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count_q[i] <= count_q[i] + 1'b1;
          2'b01:   count_q[i] <= count_q[i] - 1'b1;
          default: count_q[i] <= count_q[i];
        endcase
        if (bus.re[i] && full[i]) ovf_q[i] <= 1'b1;
      end
    end
  end

  // Issue on ready only moves mem_raddr/dch after the edge, so the bus shows the completing request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      mem_re_q    <= 1'b0;
      mem_raddr_q <= '0;
      dch_q       <= '0;
    end else begin
      mem_re_q <= 1'b0;
      if (issue) begin
        state_q     <= StWait;
        mem_re_q    <= 1'b1;
        mem_raddr_q <= fifo_mem[winner][head_q[winner]];
        dch_q       <= winner;
      end else if ((state_q == StWait) && bus.mem_ready) begin
        state_q <= StIdle;
      end
    end
  end

  assign bus.full       = full;
  assign bus.ovf        = ovf_q;
  assign bus.mem_re     = mem_re_q;
  assign bus.mem_raddr  = mem_raddr_q;
  assign bus.dready     = bus.mem_ready && (state_q == StWait);
  assign bus.draddr_out = mem_raddr_q;
  assign bus.ddata      = bus.mem_rdata;
  assign bus.dch        = dch_q;
endmodule

// File: tb/tb_memctl_mc.sv
// Self-checking bench for memctl_mc: queue-based reference model, memory responder,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_memctl_mc;
  localparam int unsigned NCH = 2, CW = 1, AW = 16, DW = 16, DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memctl_mc_if #(.NCH(NCH), .CW(CW), .AW(AW), .DW(DW)) bus ();

  memctl_mc #(.NCH(NCH), .CW(CW), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] fdat(input logic [AW-1:0] a);
    return a ^ 16'hBEAF;
  endfunction

  // ---------------- reference model (queues) ----------------
  logic [AW-1:0]  mq [NCH][$];
  bit             m_busy = 0;
  bit             m_re   = 0;
  logic [AW-1:0]  m_addr = '0;
  int             m_dch  = 0;
  int             m_last = NCH - 1;
  logic [NCH-1:0] m_ovf  = '0;
  logic [NCH-1:0] m_prefull;
  int             m_w;

  function automatic int pick();
`ifdef MEMCTL_PRIO_EN
    for (int i = 0; i < NCH; i++) if (mq[i].size() != 0) return i;
`else
    for (int k = 1; k <= NCH; k++) begin
      int c = (m_last + k) % NCH;
      if (mq[c].size() != 0) return c;
    end
`endif
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) mq[i].delete();
      m_busy = 0; m_re = 0; m_addr = '0; m_dch = 0; m_last = NCH - 1; m_ovf = '0;
    end else begin
      for (int i = 0; i < NCH; i++) m_prefull[i] = (mq[i].size() == DEPTH);
      m_w  = pick();
      m_re = 0;
      if (m_w >= 0 && (!m_busy || bus.mem_ready)) begin
        m_addr = mq[m_w].pop_front();
        m_dch  = m_w;
        m_last = m_w;
        m_busy = 1;
        m_re   = 1;
      end else if (m_busy && bus.mem_ready) begin
        m_busy = 0;
      end
      for (int i = 0; i < NCH; i++) begin
        if (bus.re[i]) begin
          if (m_prefull[i]) m_ovf[i] = 1'b1;
          else mq[i].push_back(bus.raddr[i*AW +: AW]);
        end
      end
    end
  end

  // ---------------- memory responder ----------------
  bit            stall   = 0;
  bit            spur_en = 0;
  int            lat_fix = 0;
  bit            outst   = 0;
  int            r_cnt   = 0;
  logic [AW-1:0] r_addr  = '0;

  always @(negedge clk) begin
    if (bus.mem_re === 1'b1) begin
      outst  = 1;
      r_addr = bus.mem_raddr;
      r_cnt  = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
    end
    if (outst && r_cnt == 0 && !stall) begin
      bus.mem_ready = 1'b1;
      bus.mem_rdata = fdat(r_addr);
      outst = 0;
    end else begin
      if (outst && r_cnt != 0) r_cnt--;
      bus.mem_ready = (!outst && spur_en && $urandom_range(0, 5) == 0);
      bus.mem_rdata = DW'($urandom);
    end
  end

  // ---------------- per-cycle compare ----------------
  typedef struct { int ch; logic [AW-1:0] addr; logic [DW-1:0] data; } res_t;
  res_t           res [$];
  res_t           iss [$];
  bit             full_seen = 0;
  logic [NCH-1:0] e_full;
  logic           e_dready;

  always begin
    @(negedge clk);
    #2;
    for (int i = 0; i < NCH; i++) e_full[i] = (mq[i].size() == DEPTH);
    e_dready = bus.mem_ready && m_busy;
    n_tests++;
    if (bus.mem_re !== m_re || bus.mem_raddr !== m_addr || bus.draddr_out !== m_addr ||
        bus.dch !== CW'(m_dch) || bus.full !== e_full || bus.ovf !== m_ovf ||
        bus.dready !== e_dready || (e_dready && bus.ddata !== fdat(m_addr))) begin
      n_fail++;
      $display("FAIL cycle t=%0t: got re=%b ra=%h dra=%h dch=%h full=%b ovf=%b rdy=%b dd=%h; expected re=%b ra=%h dch=%0d full=%b ovf=%b rdy=%b dd=%h",
               $time, bus.mem_re, bus.mem_raddr, bus.draddr_out, bus.dch, bus.full, bus.ovf,
               bus.dready, bus.ddata, m_re, m_addr, m_dch, e_full, m_ovf, e_dready, fdat(m_addr));
    end
    if (bus.dready === 1'b1) res.push_back('{int'(bus.dch), bus.draddr_out, bus.ddata});
    if (bus.mem_re === 1'b1) iss.push_back('{int'(bus.dch), bus.mem_raddr, '0});
    if (bus.full !== '0) full_seen = 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic [NCH-1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.re    = en;
    bus.raddr = {a1, a0};
    @(negedge clk);
    bus.re = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    res.delete();
    iss.delete();
  endtask

  task automatic wait_res(input int n);
    int t = 0;
    while (res.size() < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    #3;
    chk("result_count", res.size(), n);
  endtask

  initial begin
    bus.re = '0; bus.raddr = '0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;

    // Reset values
    @(negedge clk); #2;
    chk("rst_mem_re", bus.mem_re, 0);
    chk("rst_mem_raddr", bus.mem_raddr, 0);
    chk("rst_dch", bus.dch, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_dready", bus.dready, 0);
    do_reset();

    // Single request
    lat_fix = 2;
    push(2'b01, 16'h0040, 16'h0);
    @(negedge clk); #2;
    chk("t1_mem_re", bus.mem_re, 1);
    chk("t1_mem_raddr", bus.mem_raddr, 16'h0040);
    wait_res(1);
    if (res.size() >= 1) begin
      chk("t1_ddata", res[0].data, 16'hBEEF);
      chk("t1_draddr", res[0].addr, 16'h0040);
      chk("t1_dch", res[0].ch, 0);
    end

    // Round-robin
    do_reset();
    lat_fix = 1;
    push(2'b11, 16'h10, 16'h20);
    push(2'b11, 16'h11, 16'h21);
    wait_res(4);
    if (iss.size() >= 4) begin
      chk("rr_a0", iss[0].addr, 16'h10); chk("rr_c0", iss[0].ch, 0);
      chk("rr_a1", iss[1].addr, 16'h20); chk("rr_c1", iss[1].ch, 1);
      chk("rr_a2", iss[2].addr, 16'h11); chk("rr_c2", iss[2].ch, 0);
      chk("rr_a3", iss[3].addr, 16'h21); chk("rr_c3", iss[3].ch, 1);
    end

    // Overflow: ch0 request holds memory stalled, then 5 pushes into ch1
    do_reset();
    stall = 1; lat_fix = 0;
    push(2'b01, 16'h000F, 16'h0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) push(2'b10, 16'h0, 16'h50 + 16'(k));
    #2;
    chk("ovf_full1", bus.full[1], 1);
    chk("ovf_pre", bus.ovf[1], 0);
    push(2'b10, 16'h0, 16'h54);
    #2;
    chk("ovf_set", bus.ovf[1], 1);
    stall = 0;
    wait_res(5);
    if (res.size() >= 5) begin
      for (int k = 1; k < 5; k++) begin
        chk("ovf_order", res[k].addr, 16'h50 + 16'(k - 1));
        chk("ovf_ch", res[k].ch, 1);
      end
    end
    chk("ovf_sticky", bus.ovf[1], 1);

    // Reset while waiting on memory; stale ready must be ignored
    stall = 1; lat_fix = 1;
    push(2'b11, 16'h0077, 16'h0088);
    @(negedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    stall = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #2;
      chk("mid_rst_dready", bus.dready, 0);
      chk("mid_rst_mem_re", bus.mem_re, 0);
    end
    chk("mid_rst_full", bus.full, 0);
    chk("mid_rst_ovf", bus.ovf, 0);

    // Wrap-around with at most 2 outstanding
    do_reset();
    lat_fix = -1; full_seen = 0;
    for (int k = 0; k < 10; k++) begin
      int t = 0;
      while ((k - res.size()) >= 2 && t < 100) begin
        @(negedge clk);
        t++;
      end
      push(2'b01, 16'h100 + 16'(k), 16'h0);
    end
    wait_res(10);
    if (res.size() >= 10) begin
      for (int k = 0; k < 10; k++) chk("wrap_order", res[k].addr, 16'h100 + 16'(k));
    end
    chk("wrap_ovf", bus.ovf, 0);
    chk("wrap_full_seen", full_seen, 0);

`ifdef MEMCTL_PRIO_EN
    // Fixed priority: ch1 waits while ch0 keeps getting refilled
    do_reset();
    lat_fix = 0;
    push(2'b11, 16'h30, 16'h20);
    for (int k = 1; k < 7; k++) push(2'b01, 16'h30 + 16'(k), 16'h0);
    wait_res(8);
    if (res.size() >= 8) begin
      for (int k = 0; k < 7; k++) chk("prio_ch0", res[k].addr, 16'h30 + 16'(k));
      chk("prio_last_addr", res[7].addr, 16'h20);
      chk("prio_last_ch", res[7].ch, 1);
    end
`endif

    // Randomized traffic with spurious readies, stalls and occasional async resets
    do_reset();
    lat_fix = -1; spur_en = 1;
    for (int c = 0; c < 1500; c++) begin
      bus.re    = NCH'($urandom_range(0, 3) & $urandom_range(0, 3));
      bus.raddr = {16'($urandom), 16'($urandom)};
      if ($urandom_range(0, 7) == 0) stall = !stall;
      if ($urandom_range(0, 399) == 0) rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    bus.re = '0; stall = 0; spur_en = 0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
